// File: rtl/pim_vmac_if.sv
// Command/response port of the multi-lane MAC engine.
// master = issuing core side, slave = pim_vmac.
interface pim_vmac_if #(
   parameter int LANES = 4,
   parameter int DW    = 8,
   parameter int AW    = 32,
   parameter int NACC  = 4
);
   localparam int SELW = (NACC > 1) ? $clog2(NACC) : 1;

   logic                  CMD_VALID;
   logic                  CMD_READY;
   logic [1:0]            CMD_MODE;
   logic [SELW-1:0]       CMD_SEL;
   logic [LANES*DW-1:0]   CMD_A;
   logic [LANES*DW-1:0]   CMD_B;
   logic                  RSP_VALID;
   logic                  RSP_READY;
   logic [AW-1:0]         RSP_DATA;
   logic                  RSP_OVF;

   modport master (
      output CMD_VALID, CMD_MODE, CMD_SEL, CMD_A, CMD_B, RSP_READY,
      input  CMD_READY, RSP_VALID, RSP_DATA, RSP_OVF
   );

   modport slave (
      input  CMD_VALID, CMD_MODE, CMD_SEL, CMD_A, CMD_B, RSP_READY,
      output CMD_READY, RSP_VALID, RSP_DATA, RSP_OVF
   );
endinterface

// File: rtl/pim_vmac.sv
// Three-stage LANES-wide signed dot-product MAC with NACC accumulators.
// Optional PIM_VMAC_SAT_EN: saturating MAC with overflow flag (default wraps).
module pim_vmac #(
   parameter int LANES = 4,
   parameter int DW    = 8,
   parameter int AW    = 32,
   parameter int NACC  = 4
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic        HLT,
   output logic        IDLE,
   pim_vmac_if.slave   bus
);
   localparam int PW   = 2 * DW;
   localparam int SW   = PW + $clog2(LANES);
   localparam int SELW = (NACC > 1) ? $clog2(NACC) : 1;

   localparam logic [1:0] MODE_MAC  = 2'd0;
   localparam logic [1:0] MODE_LOAD = 2'd1;
   localparam logic [1:0] MODE_READ = 2'd2;
   localparam logic [1:0] MODE_CLR  = 2'd3;

   logic                  w_stall;
   logic                  w_accept;
   logic signed [PW-1:0]  w_prod [LANES];
   logic signed [SW-1:0]  w_sum;
   logic [AW-1:0]         w_acc_cur;
   logic [AW-1:0]         w_mac_res;
   logic                  w_mac_ovf;
   logic [AW-1:0]         w_new_acc;
   logic                  w_new_ovf;

   logic                  r_s1_valid;
   logic [1:0]            r_s1_mode;
   logic [SELW-1:0]       r_s1_sel;
   logic signed [PW-1:0]  r_prod [LANES];

   logic                  r_s2_valid;
   logic [1:0]            r_s2_mode;
   logic [SELW-1:0]       r_s2_sel;
   logic signed [AW-1:0]  r_dot;

   logic                  r_rsp_valid;
   logic [AW-1:0]         r_rsp_data;
   logic                  r_rsp_ovf;
   logic [AW-1:0]         r_acc [NACC];

   assign w_stall       = HLT | (r_rsp_valid & ~bus.RSP_READY);
   assign bus.CMD_READY = RES & ~w_stall;
   assign w_accept      = bus.CMD_VALID & bus.CMD_READY;

   assign bus.RSP_VALID = r_rsp_valid;
   assign bus.RSP_DATA  = r_rsp_data;
   assign bus.RSP_OVF   = r_rsp_ovf;
   assign IDLE          = ~(r_s1_valid | r_s2_valid | r_rsp_valid);

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         w_prod[i] = PW'($signed(bus.CMD_A[i*DW +: DW])) * PW'($signed(bus.CMD_B[i*DW +: DW]));
      end
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         w_sum = w_sum + SW'(r_prod[i]);
      end
   end

   assign w_acc_cur = r_acc[r_s2_sel];

`ifdef PIM_VMAC_SAT_EN
   logic [AW:0] w_add;
   // One guard bit: overflow iff the guard and the sign bit disagree.
   assign w_add     = {w_acc_cur[AW-1], w_acc_cur} + {r_dot[AW-1], r_dot};
   assign w_mac_ovf = w_add[AW] ^ w_add[AW-1];
   assign w_mac_res = w_mac_ovf ? (w_add[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}})
                                : w_add[AW-1:0];
`else
   assign w_mac_ovf = 1'b0;
   assign w_mac_res = w_acc_cur + r_dot;
`endif

   always_comb begin
      w_new_acc = w_acc_cur;
      w_new_ovf = 1'b0;
      case (r_s2_mode)
         MODE_MAC: begin
            w_new_acc = w_mac_res;
            w_new_ovf = w_mac_ovf;
         end
         MODE_LOAD: w_new_acc = r_dot;
         MODE_READ: w_new_acc = w_acc_cur;
         MODE_CLR:  w_new_acc = '0;
         default:   w_new_acc = w_acc_cur;
      endcase
   end

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         r_s1_valid <= 1'b0;
         r_s1_mode  <= '0;
         r_s1_sel   <= '0;
         for (int i = 0; i < LANES; i++) r_prod[i] <= '0;
         r_s2_valid <= 1'b0;
         r_s2_mode  <= '0;
         r_s2_sel   <= '0;
         r_dot      <= '0;
      end else if (!w_stall) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_mode <= bus.CMD_MODE;
            r_s1_sel  <= bus.CMD_SEL;
            for (int i = 0; i < LANES; i++) r_prod[i] <= w_prod[i];
         end
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_mode <= r_s1_mode;
            r_s2_sel  <= r_s1_sel;
            r_dot     <= AW'(w_sum);
         end
      end
   end

   // Accumulator RMW and response register share one stage, so back-to-back
   // commands on the same SEL see each other's results without forwarding.
   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_ovf   <= 1'b0;
         for (int i = 0; i < NACC; i++) r_acc[i] <= '0;
      end else if (!w_stall) begin
         r_rsp_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_acc[r_s2_sel] <= w_new_acc;
            r_rsp_data      <= w_new_acc;
            r_rsp_ovf       <= w_new_ovf;
         end
      end
   end
endmodule

// File: tb/tb_pim_vmac.sv
// Scoreboard bench for pim_vmac: accepted commands push model results,
// a negedge monitor pops and compares on every response handshake.
module tb_pim_vmac;
   localparam int LANES = 4;
   localparam int DW    = 8;
   localparam int AW    = 32;
   localparam int NACC  = 4;

   typedef struct {
      longint data;
      bit     ovf;
   } exp_t;

   logic clk   = 1'b0;
   logic res_n = 1'b0;
   logic hlt   = 1'b0;
   logic hlt18 = 1'b0;
   logic idle;
   logic idle18;

   pim_vmac_if #(.LANES(LANES), .DW(DW), .AW(AW), .NACC(NACC)) bus ();
   pim_vmac_if #(.LANES(LANES), .DW(DW), .AW(18), .NACC(NACC)) bus18 ();

   pim_vmac #(.LANES(LANES), .DW(DW), .AW(AW), .NACC(NACC)) dut (
      .CLK(clk), .RES(res_n), .HLT(hlt), .IDLE(idle), .bus(bus)
   );

   pim_vmac #(.LANES(LANES), .DW(DW), .AW(18), .NACC(NACC)) dut18 (
      .CLK(clk), .RES(res_n), .HLT(hlt18), .IDLE(idle18), .bus(bus18)
   );

   always #5 clk = ~clk;

   int     compared   = 0;
   int     mismatched = 0;
   int     cyc        = 0;
   exp_t   sbq[$];
   int     hs_cyc[$];
   longint acc_m[NACC];
   bit     prev_valid = 0;
   bit     prev_taken = 0;
   longint prev_data  = 0;

   always @(posedge clk) cyc++;

   task automatic chk(string name, longint act, longint exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint wrapw(longint v, int aw);
      return (v <<< (64 - aw)) >>> (64 - aw);
   endfunction

   function automatic longint dot_of(logic [LANES*DW-1:0] a, logic [LANES*DW-1:0] b);
      longint s = 0;
      for (int i = 0; i < LANES; i++)
         s += longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
      return s;
   endfunction

   function automatic logic [31:0] pack4(int l0, int l1, int l2, int l3);
      logic [31:0] r;
      r[7:0]   = l0[7:0];
      r[15:8]  = l1[7:0];
      r[23:16] = l2[7:0];
      r[31:24] = l3[7:0];
      return r;
   endfunction

   function automatic logic [31:0] rand_ops();
      logic [31:0] r;
      for (int i = 0; i < LANES; i++) begin
         case ($urandom_range(0, 3))
            0:       r[i*8 +: 8] = 8'h80;
            1:       r[i*8 +: 8] = 8'h7f;
            default: r[i*8 +: 8] = 8'($urandom);
         endcase
      end
      return r;
   endfunction

   // Reference: accumulator semantics computed in plain integer arithmetic.
   function automatic exp_t model_step(int mode, int sel, logic [31:0] a, logic [31:0] b);
      exp_t   e;
      longint dot  = dot_of(a, b);
      longint cur  = acc_m[sel];
      longint maxv = (longint'(1) <<< (AW - 1)) - 1;
      longint minv = -(longint'(1) <<< (AW - 1));
      longint s;
      e.ovf = 0;
      case (mode)
         0: begin
            s = cur + dot;
`ifdef PIM_VMAC_SAT_EN
            if (s > maxv) begin s = maxv; e.ovf = 1; end
            else if (s < minv) begin s = minv; e.ovf = 1; end
`else
            s = wrapw(s, AW);
`endif
         end
         1:       s = wrapw(dot, AW);
         2:       s = cur;
         default: s = 0;
      endcase
      acc_m[sel] = s;
      e.data = s;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      bit   taken;
      if (!res_n) begin
         sbq.delete();
         for (int i = 0; i < NACC; i++) acc_m[i] = 0;
         prev_valid = 0;
         prev_taken = 0;
      end else begin
         if (prev_valid && !prev_taken) begin
            chk("rsp_hold_valid", bus.RSP_VALID, 1);
            chk("rsp_hold_data", longint'($signed(bus.RSP_DATA)), prev_data);
         end
         chk("cmd_ready", bus.CMD_READY, !(hlt || (bus.RSP_VALID && !bus.RSP_READY)));
         if (bus.CMD_VALID && bus.CMD_READY) begin
            e = model_step(int'(bus.CMD_MODE), int'(bus.CMD_SEL), bus.CMD_A, bus.CMD_B);
            sbq.push_back(e);
         end
         taken = bus.RSP_VALID && bus.RSP_READY && !hlt;
         if (taken) begin
            if (sbq.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL rsp_unexpected: got data %0d with no command outstanding",
                        longint'($signed(bus.RSP_DATA)));
            end else begin
               e = sbq.pop_front();
               chk("rsp_data", longint'($signed(bus.RSP_DATA)), e.data);
               chk("rsp_ovf", bus.RSP_OVF, e.ovf);
            end
            hs_cyc.push_back(cyc);
         end
         prev_valid = bus.RSP_VALID;
         prev_data  = longint'($signed(bus.RSP_DATA));
         prev_taken = taken;
      end
   end

   task automatic send(int mode, int sel, logic [31:0] a, logic [31:0] b);
      bus.CMD_VALID = 1'b1;
      bus.CMD_MODE  = mode[1:0];
      bus.CMD_SEL   = sel[1:0];
      bus.CMD_A     = a;
      bus.CMD_B     = b;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (bus.CMD_READY) begin
            @(posedge clk);
            #1;
            bus.CMD_VALID = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got no CMD_READY in 100 cycles, expected accept");
      bus.CMD_VALID = 1'b0;
   endtask

   task automatic directed(string name, int mode, int sel, logic [31:0] a, logic [31:0] b,
                           longint exp);
      send(mode, sel, a, b);
      chk({name, "_lat0"}, bus.RSP_VALID, 0);
      @(posedge clk); #1;
      chk({name, "_lat1"}, bus.RSP_VALID, 0);
      @(posedge clk); #1;
      chk({name, "_valid"}, bus.RSP_VALID, 1);
      chk({name, "_data"}, longint'($signed(bus.RSP_DATA)), exp);
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(string name, int budget);
      for (int t = 0; t < budget; t++) begin
         @(posedge clk); #1;
         if (idle && sbq.size() == 0) return;
      end
      compared++;
      mismatched++;
      $display("FAIL %s_drain: got %0d outstanding after %0d cycles, expected 0",
               name, sbq.size(), budget);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] va, vb, m128;
      bus.CMD_VALID   = 0;
      bus.CMD_MODE    = 0;
      bus.CMD_SEL     = 0;
      bus.CMD_A       = 0;
      bus.CMD_B       = 0;
      bus.RSP_READY   = 1;
      bus18.CMD_VALID = 0;
      bus18.CMD_MODE  = 0;
      bus18.CMD_SEL   = 0;
      bus18.CMD_A     = 0;
      bus18.CMD_B     = 0;
      bus18.RSP_READY = 1;
      m128 = 32'h80808080;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_idle", idle, 1);
      chk("rst_cmd_ready", bus.CMD_READY, 0);
      chk("rst_rsp_valid", bus.RSP_VALID, 0);
      chk("rst_rsp_data", longint'(bus.RSP_DATA), 0);
      res_n = 1;
      @(posedge clk); #1;

      va = pack4(1, 2, 3, 4);
      vb = pack4(5, 6, 7, 8);
      directed("load0", 1, 0, va, vb, 70);
      directed("mac0", 0, 0, va, vb, 140);
      directed("read0", 2, 0, va, vb, 140);

      hs_cyc.delete();
      for (int i = 0; i < 4; i++) send(0, 1, m128, m128);
      wait_idle("b2b", 20);
      chk("b2b_count", hs_cyc.size(), 4);
      if (hs_cyc.size() == 4) chk("b2b_span", hs_cyc[3] - hs_cyc[0], 3);
      directed("read1", 2, 1, 0, 0, 262144);
      directed("read0_kept", 2, 0, 0, 0, 140);

      bus.RSP_READY = 0;
      for (int i = 0; i < 3; i++) send(0, 3, rand_ops(), rand_ops());
      repeat (5) begin
         @(negedge clk);
         chk("bp_cmd_ready", bus.CMD_READY, 0);
         chk("bp_rsp_valid", bus.RSP_VALID, 1);
      end
      @(posedge clk); #1;
      hs_cyc.delete();
      bus.RSP_READY = 1;
      wait_idle("bp", 20);
      chk("bp_count", hs_cyc.size(), 3);

      fork
         begin
            for (int i = 0; i < 6; i++) send(0, 2, rand_ops(), rand_ops());
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            hlt = 1;
            repeat (4) begin
               @(negedge clk);
               chk("hlt_cmd_ready", bus.CMD_READY, 0);
            end
            @(posedge clk); #1;
            hlt = 0;
         end
      join
      wait_idle("hlt", 30);

      send(0, 1, rand_ops(), rand_ops());
      send(0, 2, rand_ops(), rand_ops());
      res_n = 0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_mid_idle", idle, 1);
         chk("rst_mid_cmd_ready", bus.CMD_READY, 0);
         chk("rst_mid_rsp_valid", bus.RSP_VALID, 0);
      end
      @(posedge clk); #1;
      res_n = 1;
      for (int s = 0; s < NACC; s++) directed("read_after_rst", 2, s, 0, 0, 0);

      bus18.CMD_VALID = 1;
      bus18.CMD_MODE  = 2'd1;
      bus18.CMD_SEL   = 0;
      bus18.CMD_A     = m128;
      bus18.CMD_B     = m128;
      @(posedge clk); #1;
      bus18.CMD_MODE  = 2'd0;
      @(posedge clk); #1;
      bus18.CMD_VALID = 0;
      @(posedge clk); #1;
      chk("aw18_load_valid", bus18.RSP_VALID, 1);
      chk("aw18_load_data", longint'($signed(bus18.RSP_DATA)), 65536);
      chk("aw18_load_ovf", bus18.RSP_OVF, 0);
      @(posedge clk); #1;
      chk("aw18_mac_valid", bus18.RSP_VALID, 1);
`ifdef PIM_VMAC_SAT_EN
      chk("aw18_mac_data", longint'($signed(bus18.RSP_DATA)), 131071);
      chk("aw18_mac_ovf", bus18.RSP_OVF, 1);
`else
      chk("aw18_mac_data", longint'($signed(bus18.RSP_DATA)), -131072);
      chk("aw18_mac_ovf", bus18.RSP_OVF, 0);
`endif
      @(posedge clk); #1;

      for (int n = 0; n < 400; n++) begin
         bus.CMD_VALID = ($urandom_range(0, 3) != 0);
         bus.CMD_MODE  = 2'($urandom_range(0, 3));
         bus.CMD_SEL   = 2'($urandom_range(0, NACC - 1));
         bus.CMD_A     = rand_ops();
         bus.CMD_B     = rand_ops();
         bus.RSP_READY = ($urandom_range(0, 3) != 0);
         hlt           = ($urandom_range(0, 9) == 0);
         @(posedge clk); #1;
      end
      bus.CMD_VALID = 0;
      bus.RSP_READY = 1;
      hlt           = 0;
      wait_idle("rand", 50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
